// File: rtl/spart_driver_if.sv
// SPART processor-side control bus.
// Master: spart_driver; slave: the SPART.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    input  rda,
    input  tbr
  );

  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    output rda,
    output tbr
  );
endinterface

// File: rtl/spart_driver.sv
// spart_driver: programs the SPART divisor, then services rx/tx.
// Optional echo of received bytes: define SPART_DRV_ECHO_EN.
module spart_driver #(
  parameter logic [15:0] DIV0 = 16'h0515,
  parameter logic [15:0] DIV1 = 16'h028A,
  parameter logic [15:0] DIV2 = 16'h0144,
  parameter logic [15:0] DIV3 = 16'h00A2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     br_cfg,
  spart_driver_if.master bus,
  inout  wire  [7:0]     databus,
  input  logic [7:0]     tx_data,
  input  logic           tx_req,
  output logic           tx_ack,
  output logic [7:0]     rx_data,
  output logic           rx_valid,
  output logic           ready
);

  typedef enum logic [3:0] {
    INIT_LO,
    INIT_HI,
    IDLE,
    RX_RD,
    RX_DONE,
    TX_WAIT,
    TX_WR,
    TX_GAP
`ifdef SPART_DRV_ECHO_EN
    ,
    ECHO_WAIT,
    ECHO_WR
`endif
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       armed_q;
  logic [1:0] cfg_q;

  logic       iocs_q;
  logic       iorw_q;
  logic [1:0] addr_q;
  logic [7:0] dout_q;
  logic       ack_q;
  logic       valid_q;
  logic       ready_q;

  logic       iocs_d;
  logic       iorw_d;
  logic [1:0] addr_d;
  logic [7:0] dout_d;
  logic       ack_d;
  logic       valid_d;
  logic       ready_d;

  logic [15:0] div_new;
  logic [15:0] div_cur;

  function automatic logic [15:0] div_sel(
    input logic [1:0] c
  );
    logic [15:0] d;
    unique case (c)
      2'b00:   d = DIV0;
      2'b01:   d = DIV1;
      2'b10:   d = DIV2;
      default: d = DIV3;
    endcase
    return d;
  endfunction

  assign div_new = div_sel(br_cfg);
  assign div_cur = div_sel(cfg_q);

  // Next-state selection; rx beats tx, re-init beats both.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT_LO: if (armed_q) state_d = INIT_HI;
      INIT_HI: state_d = IDLE;
      IDLE: begin
        if (br_cfg != cfg_q) state_d = INIT_LO;
        else if (bus.rda)    state_d = RX_RD;
        else if (tx_req)     state_d = TX_WAIT;
      end
      RX_RD: state_d = RX_DONE;
`ifdef SPART_DRV_ECHO_EN
      RX_DONE:   state_d = ECHO_WAIT;
      ECHO_WAIT: if (bus.tbr) state_d = ECHO_WR;
      ECHO_WR:   state_d = TX_GAP;
`else
      RX_DONE: state_d = IDLE;
`endif
      TX_WAIT: begin
        if (!tx_req)      state_d = IDLE;
        else if (bus.tbr) state_d = TX_WR;
      end
      TX_WR:   state_d = TX_GAP;
      TX_GAP:  state_d = IDLE;
      default: state_d = INIT_LO;
    endcase
  end

  // Bus and strobe values for the state being entered.
  always_comb begin
    iocs_d  = 1'b0;
    iorw_d  = 1'b0;
    addr_d  = 2'b01;
    dout_d  = 8'h00;
    ack_d   = 1'b0;
    valid_d = 1'b0;
    ready_d = 1'b0;
    unique case (state_d)
      INIT_LO: begin
        iocs_d = 1'b1;
        addr_d = 2'b10;
        dout_d = div_new[7:0];
      end
      INIT_HI: begin
        iocs_d = 1'b1;
        addr_d = 2'b11;
        dout_d = div_cur[15:8];
      end
      IDLE: ready_d = 1'b1;
      RX_RD: begin
        iocs_d = 1'b1;
        iorw_d = 1'b1;
        addr_d = 2'b00;
      end
      RX_DONE: valid_d = 1'b1;
      TX_WR: begin
        iocs_d = 1'b1;
        addr_d = 2'b00;
        dout_d = tx_data;
        ack_d  = 1'b1;
      end
`ifdef SPART_DRV_ECHO_EN
      ECHO_WR: begin
        iocs_d = 1'b1;
        addr_d = 2'b00;
        dout_d = rx_data;
      end
`endif
      default: ;
    endcase
  end

  // State, config latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT_LO;
      armed_q  <= 1'b0;
      cfg_q    <= 2'b00;
      iocs_q   <= 1'b0;
      iorw_q   <= 1'b0;
      addr_q   <= 2'b01;
      dout_q   <= 8'h00;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (state_d == INIT_LO) cfg_q <= br_cfg;
      iocs_q  <= iocs_d;
      iorw_q  <= iorw_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      if (state_q == RX_RD) rx_data <= databus;
    end
  end

  assign bus.iocs   = iocs_q;
  assign bus.iorw   = iorw_q;
  assign bus.ioaddr = addr_q;
  assign databus    = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
  assign tx_ack     = ack_q;
  assign rx_valid   = valid_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_spart_driver.sv
// Scoreboard bench for spart_driver with a SPART-side model.
// Build with SPART_DRV_ECHO_EN to exercise the echo path.
module tb_spart_driver;

  localparam int K_W = 0;
  localparam int K_R = 1;
  localparam int K_V = 2;
  localparam int K_A = 3;

  typedef struct {
    int         kind;
    logic [1:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req = 1'b0;
  logic       tx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ready;
  logic [7:0] spart_rx = 8'h00;
  wire  [7:0] databus;

  int checks = 0;
  int errors = 0;
  ev_t q[$];
  logic [15:0] div_tab [4];

  spart_driver_if bus();

  spart_driver dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .bus      (bus),
    .databus  (databus),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .tx_ack   (tx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .ready    (ready)
  );

  assign databus = (bus.iocs && bus.iorw && bus.ioaddr == 2'b00)
                   ? spart_rx : 8'hzz;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic push(input int k, input logic [1:0] a,
                      input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic exp_init(input logic [1:0] c);
    logic [15:0] d;
    d = div_tab[c];
    push(K_W, 2'b10, d[7:0]);
    push(K_W, 2'b11, d[15:8]);
  endtask

  task automatic exp_rx(input logic [7:0] b);
    push(K_R, 2'b00, b);
    push(K_V, 2'b00, b);
`ifdef SPART_DRV_ECHO_EN
    push(K_W, 2'b00, b);
`endif
  endtask

  task automatic exp_tx(input logic [7:0] t);
    push(K_W, 2'b00, t);
    push(K_A, 2'b00, 8'h00);
  endtask

  task automatic check_ev(input string nm, input int k,
                          input logic [1:0] a, input logic [7:0] d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected kind=%0d addr=%0d data=%h",
               nm, k, a, d);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        errors++;
        $display("FAIL %s: got kind=%0d addr=%0d data=%h want kind=%0d addr=%0d data=%h",
                 nm, k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every bus access and strobe is matched against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.iocs) begin
        check_ev("bus", bus.iorw ? K_R : K_W, bus.ioaddr, databus);
        chk("ready_busy", 32'(ready), 32'd0);
        if (!bus.iorw && bus.ioaddr == 2'b00)
          chk("tbr_at_write", 32'(bus.tbr), 32'd1);
      end else begin
        chk("idle_bus", {29'd0, bus.iorw, bus.ioaddr}, 32'd1);
      end
      if (rx_valid) check_ev("rx_valid", K_V, 2'b00, rx_data);
      if (tx_ack)   check_ev("tx_ack", K_A, 2'b00, 8'h00);
    end
  end

  // SPART model: rda clears on the read, tbr drops after a write.
  task automatic settle(input string nm, input int tdelay);
    int n;
    int tcnt;
    n = 0;
    tcnt = tdelay;
    while (n < 400) begin
      @(negedge clk);
      #1;
      if (bus.iocs && bus.iorw && bus.ioaddr == 2'b00) bus.rda = 1'b0;
      if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) begin
        bus.tbr = 1'b0;
        tcnt = $urandom_range(0, 4);
      end else if (!bus.tbr) begin
        if (tcnt == 0) bus.tbr = 1'b1;
        else tcnt--;
      end
      if (tx_ack) tx_req = 1'b0;
      if (q.size() == 0 && !bus.rda && !tx_req && ready) break;
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s: timeout, %0d events pending", nm, q.size());
      q.delete();
      tx_req = 1'b0;
      bus.rda = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] b;
    logic [7:0] t;
    logic [1:0] c;
    div_tab[0] = 16'h0515;
    div_tab[1] = 16'h028A;
    div_tab[2] = 16'h0144;
    div_tab[3] = 16'h00A2;
    bus.rda = 1'b0;
    bus.tbr = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_iocs", 32'(bus.iocs), 32'd0);
    chk("rst_iorw", 32'(bus.iorw), 32'd0);
    chk("rst_ioaddr", 32'(bus.ioaddr), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_ack", 32'(tx_ack), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);

    exp_init(2'b01);
    rst = 1'b0;
    settle("init", 0);
    chk("ready_after_init", 32'(ready), 32'd1);

    bus.tbr = 1'b0;
    spart_rx = 8'h5A;
    exp_rx(8'h5A);
    bus.rda = 1'b1;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      #1;
      if (bus.iocs && bus.iorw && bus.ioaddr == 2'b00) bus.rda = 1'b0;
      if (rx_valid && lat == 0) lat = i;
    end
    chk("rx_latency", 32'(lat), 32'd2);
    chk("rx_data_5a", 32'(rx_data), 32'h5A);
    settle("rx_5a", 2);

    bus.tbr = 1'b1;
    tx_data = 8'h3C;
    exp_tx(8'h3C);
    tx_req = 1'b1;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      #1;
      if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) bus.tbr = 1'b0;
      if (tx_ack && lat == 0) begin
        lat = i;
        tx_req = 1'b0;
      end
    end
    chk("tx_latency", 32'(lat), 32'd2);
    settle("tx_3c", 0);

    bus.tbr = 1'b0;
    tx_data = 8'hC3;
    exp_tx(8'hC3);
    tx_req = 1'b1;
    settle("tx_c3_wait", 10);

    spart_rx = 8'h77;
    tx_data = 8'h99;
    exp_rx(8'h77);
    exp_tx(8'h99);
    bus.rda = 1'b1;
    tx_req = 1'b1;
    settle("rx_tx_same", 1);

    br_cfg = 2'b11;
    exp_init(2'b11);
    settle("reinit_11", 0);

    bus.tbr = 1'b0;
    tx_data = 8'hE1;
    tx_req = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_iocs", 32'(bus.iocs), 32'd0);
    chk("midrst_ack", 32'(tx_ack), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    q.delete();
    tx_req = 1'b0;
    exp_init(br_cfg);
    @(negedge clk);
    #1;
    rst = 1'b0;
    settle("reinit_rst", 0);

    for (int n = 0; n < 60; n++) begin
      int op;
      op = $urandom_range(0, 3);
      b = 8'($urandom);
      t = 8'($urandom);
      bus.tbr = 1'($urandom_range(0, 1));
      case (op)
        0: begin
          spart_rx = b;
          exp_rx(b);
          bus.rda = 1'b1;
        end
        1: begin
          tx_data = t;
          exp_tx(t);
          tx_req = 1'b1;
        end
        2: begin
          spart_rx = b;
          tx_data = t;
          exp_rx(b);
          exp_tx(t);
          bus.rda = 1'b1;
          tx_req = 1'b1;
        end
        default: begin
          c = 2'($urandom_range(0, 3));
          if (c == br_cfg) c = c + 2'd1;
          br_cfg = c;
          exp_init(c);
        end
      endcase
      settle("random_op", $urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
